cursor_overlay_ctrl: RTL and testbench
======================================

# cursor_overlay_ctrl

Sequencer for the 16x16, 1-bit-per-pixel mouse-cursor bitmap ROM (32 x 8-bit, 5-bit address, combinational read). During horizontal blanking it fetches the two bytes for the next scan line's cursor row into a line buffer. During active video it shifts that buffer out as a per-pixel overlay flag for the VGA colour mux. Cursor position and enable are latched once per frame, so the cursor never tears.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, total lines per frame, including blanking
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- pix_valid  in  1  one pixel per asserted cycle; hcnt/vcnt describe that pixel
- hcnt  in  10  horizontal pixel counter
- vcnt  in  10  vertical line counter
- mouse_x  in  10  cursor hot-spot column (top-left of bitmap)
- mouse_y  in  10  cursor hot-spot row
- cursor_en  in  1  show cursor
- rom_addr  out  5  ROM address
- rom_data  in  8  ROM data; valid in the same cycle as rom_addr
- out_valid  out  1  pix_valid delayed 1 cycle
- cursor_px  out  1  draw cursor colour on this pixel
- cursor_box  out  1  pixel lies inside the 16x16 cursor box

## Operation
- Bitmap format:
  - row r is at addresses 2r (columns 0-7) and 2r+1 (columns 8-15)
  - the MSB of each byte is the leftmost column
  - bit 0 = cursor pixel, bit 1 = transparent
- Fetch trigger: pix_valid && hcnt==H_ACTIVE.
  - Target line is tline = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
  - When vcnt==V_TOTAL-1 at the trigger (frame start), cx<=mouse_x, cy<=mouse_y, en_q<=cursor_en are latched in the same cycle.
- FSM states: IDLE, CHECK, FETCH_L, FETCH_R.
  - IDLE, on trigger: register tline, go to CHECK.
  - CHECK: compute hit = en_q && tline<V_ACTIVE && tline>=cy && tline-cy<16, using 11-bit arithmetic.
    - hit: row<=tline-cy (4 bits), go to FETCH_L.
    - miss: line_buf<=16'hFFFF, go to IDLE.
  - FETCH_L: rom_addr={row,1'b0}; line_buf[15:8]<=rom_data; go to FETCH_R.
  - FETCH_R: rom_addr={row,1'b1}; line_buf[7:0]<=rom_data; go to IDLE.
  - A trigger while not in IDLE is ignored.
- rom_addr is decoded from state and row; it is 0 in IDLE and CHECK.
- Pixel path, evaluated on every cycle with pix_valid && hcnt<H_ACTIVE && vcnt<V_ACTIVE:
  - box = hcnt>=cx && hcnt-cx<16 (11-bit compare); col = hcnt-cx.
  - cursor_box<=box; cursor_px<=box & ~line_buf[15-col].
- When pix_valid is low, or the pixel is outside the active area, cursor_px and cursor_box register 0.
- Clipping:
  - A cursor extending past H_ACTIVE or V_ACTIVE is truncated.
  - There is no wrap to column 0 or line 0.
- mouse_x, mouse_y and cursor_en changes mid-frame have no effect until the next frame-start trigger.

## Timing
- Reset values:
  - state IDLE, line_buf 16'hFFFF, cx=cy=0, en_q=0, row=0
  - rom_addr 0, out_valid 0, cursor_px 0, cursor_box 0
- Fetch takes 4 cycles from trigger to line_buf update: trigger, CHECK, FETCH_L, FETCH_R.
- Horizontal blanking must give at least 4 clk cycles before the next line's hcnt==0 pixel. This is satisfied for any pixel rate at or below clk with 4 or more blanking pixels.
- line_buf is overwritten only after the current line's active region ends, so a single buffer suffices.
- Pixel output latency is 1 cycle: outputs at cycle n+1 describe the pixel presented at cycle n.
- Reset asserted mid-fetch:
  - the FSM returns to IDLE and the buffer becomes transparent
  - the current line shows no cursor
  - the cursor is hidden until the next frame-start trigger after reset release, which sets en_q

## Test plan
- Reset, then idle video:
  - rom_addr=0, out_valid=0, cursor_px=0, cursor_box=0 on every cycle.
  - No fetches occur until after the first frame-start trigger.
- mouse=(100,50), en=1, full frame:
  - Exactly one fetch pair per line for lines 50-65 (addresses 0/1 ... 30/31); none on other lines.
  - Line 50: cursor_px=0,1,1,0 at x=100..103.
  - cursor_box=1 exactly for x=100..115.
- Same cursor, line 60 (row 10, data 80/FF):
  - cursor_px=1 for x=101..107.
  - cursor_px=0 at x=100 and for x=108..115.
- mouse=(630,470):
  - cursor_box is asserted only for x=630..639 on lines 470..479.
  - No fetch occurs for lines >=480, and no cursor appears on line 0 or at column 0.
- mouse=(0,0):
  - Line 0 is fetched at the trigger on vcnt=V_TOTAL-1 (addresses 0,1).
  - cursor_px=1 at (1,0) and (2,0); 0 at (0,0).
- Frame latching:
  - Changing mouse_y from 50 to 200 at line 100 keeps the cursor at line 50 for the rest of the frame; the next frame shows it at 200.
  - cursor_en=0 at frame start gives zero fetches and cursor_px=0 for the whole frame.

Source files
------------

// File: rtl/cursor_overlay_ctrl.sv
// Cursor overlay sequencer: fetches the next line's 16-pixel cursor row from the bitmap ROM
// during horizontal blanking, then shifts it out as a per-pixel overlay flag during active video.
module cursor_overlay_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_valid,
    input  logic [9:0] i_hcnt,
    input  logic [9:0] i_vcnt,
    input  logic [9:0] i_mouse_x,
    input  logic [9:0] i_mouse_y,
    input  logic       i_cursor_en,
    output logic [4:0] o_rom_addr,
    input  logic [7:0] i_rom_data,
    output logic       o_out_valid,
    output logic       o_cursor_px,
    output logic       o_cursor_box
);

    localparam logic [9:0] L_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0] L_V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FETCH_L,
        FETCH_R
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [9:0]  r_tline;
    logic [3:0]  r_row;
    logic [15:0] r_lineBuf;
    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    logic        r_enQ;
    logic        r_outValid;
    logic        r_cursorPx;
    logic        r_cursorBox;

    logic        w_trigger;
    logic        w_frameStart;
    logic [9:0]  w_tlineNext;
    logic [10:0] w_dy;
    logic        w_hit;
    logic        w_active;
    logic [10:0] w_dx;
    logic        w_box;
    logic [3:0]  w_col;
    logic        w_bufBit;

    assign w_trigger    = i_pix_valid && (i_hcnt == L_H_ACTIVE);
    assign w_frameStart = w_trigger && (i_vcnt == L_V_LAST);
    assign w_tlineNext  = (i_vcnt == L_V_LAST) ? 10'd0 : i_vcnt + 10'd1;

    // Widened to 11 bits so a cursor near the bottom/right edge clips instead of wrapping.
    assign w_dy  = {1'b0, r_tline} - {1'b0, r_cy};
    assign w_hit = r_enQ && (r_tline < L_V_ACTIVE) && (r_tline >= r_cy) && (w_dy < 11'd16);

    assign w_active = i_pix_valid && (i_hcnt < L_H_ACTIVE) && (i_vcnt < L_V_ACTIVE);
    assign w_dx     = {1'b0, i_hcnt} - {1'b0, r_cx};
    assign w_box    = (i_hcnt >= r_cx) && (w_dx < 11'd16);
    assign w_col    = w_dx[3:0];
    assign w_bufBit = r_lineBuf[4'd15 - w_col];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_rom_addr  = 5'd0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_nextState = CHECK;
                end
            end
            CHECK: begin
                w_nextState = w_hit ? FETCH_L : IDLE;
            end
            FETCH_L: begin
                o_rom_addr  = {r_row, 1'b0};
                w_nextState = FETCH_R;
            end
            FETCH_R: begin
                o_rom_addr  = {r_row, 1'b1};
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Bitmap 0 bits are cursor pixels, so an all-ones buffer is fully transparent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tline     <= 10'd0;
            r_row       <= 4'd0;
            r_lineBuf   <= 16'hFFFF;
            r_cx        <= 10'd0;
            r_cy        <= 10'd0;
            r_enQ       <= 1'b0;
            r_outValid  <= 1'b0;
            r_cursorPx  <= 1'b0;
            r_cursorBox <= 1'b0;
        end else begin
            if (w_frameStart) begin
                r_cx  <= i_mouse_x;
                r_cy  <= i_mouse_y;
                r_enQ <= i_cursor_en;
            end
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_tline <= w_tlineNext;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        r_row <= w_dy[3:0];
                    end else begin
                        r_lineBuf <= 16'hFFFF;
                    end
                end
                FETCH_L: r_lineBuf[15:8] <= i_rom_data;
                FETCH_R: r_lineBuf[7:0]  <= i_rom_data;
                default: ;
            endcase
            r_outValid  <= i_pix_valid;
            r_cursorBox <= w_active && w_box;
            r_cursorPx  <= w_active && w_box && !w_bufBit;
        end
    end

    assign o_out_valid  = r_outValid;
    assign o_cursor_px  = r_cursorPx;
    assign o_cursor_box = r_cursorBox;

endmodule

// File: tb/tb_cursor_overlay_ctrl.sv
// Scoreboard bench for cursor_overlay_ctrl: stimulus pushes the expected per-cycle response,
// a monitor pops and compares one entry per clock, one cycle after the pixel is presented.
module tb_cursor_overlay_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixValid = 1'b0;
    logic [9:0] hcnt = 10'd0;
    logic [9:0] vcnt = 10'd0;
    logic [9:0] mouseX = 10'd0;
    logic [9:0] mouseY = 10'd0;
    logic       cursorEn = 1'b0;
    logic [4:0] romAddr;
    logic [7:0] romData;
    logic       outValid;
    logic       cursorPx;
    logic       cursorBox;

    logic [7:0] romMem [0:31];

    typedef struct packed {
        logic       valid;
        logic       px;
        logic       box;
        logic [4:0] addr;
    } expRec_t;

    expRec_t sb[$];

    int   checks = 0;
    int   failures = 0;

    int          mCx = 0;
    int          mCy = 0;
    bit          mEn = 1'b0;
    logic [15:0] mBuf = 16'hFFFF;
    int          fetchPhase = 0;
    logic [3:0]  fetchRow = 4'd0;

    always #5 clk = ~clk;

    assign romData = romMem[romAddr];

    cursor_overlay_ctrl dut (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_pix_valid  (pixValid),
        .i_hcnt       (hcnt),
        .i_vcnt       (vcnt),
        .i_mouse_x    (mouseX),
        .i_mouse_y    (mouseY),
        .i_cursor_en  (cursorEn),
        .o_rom_addr   (romAddr),
        .i_rom_data   (romData),
        .o_out_valid  (outValid),
        .o_cursor_px  (cursorPx),
        .o_cursor_box (cursorBox)
    );

    task automatic checkOutput(input expRec_t e);
        checks++;
        if ({outValid, cursorPx, cursorBox} !== {e.valid, e.px, e.box}) begin
            failures++;
            $display("[TB] FAIL pixel at %0t: valid/px/box got %b%b%b expected %b%b%b",
                     $time, outValid, cursorPx, cursorBox, e.valid, e.px, e.box);
        end
        checks++;
        if (romAddr !== e.addr) begin
            failures++;
            $display("[TB] FAIL romaddr at %0t: got %0d expected %0d", $time, romAddr, e.addr);
        end
    endtask

    // Drives one cycle at the falling edge and queues the response expected after the next rise.
    task automatic applyStimulus(input logic rst, input logic pv, input int h, input int v);
        expRec_t e;
        int      tline;
        bit      hit;
        @(negedge clk);
        reset    = rst;
        pixValid = pv;
        hcnt     = 10'(h);
        vcnt     = 10'(v);
        e = '0;
        if (rst) begin
            mCx = 0; mCy = 0; mEn = 1'b0; mBuf = 16'hFFFF; fetchPhase = 0;
        end else begin
            e.valid = pv;
            if (pv && h < 640 && v < 480 && h >= mCx && h - mCx < 16) begin
                e.box = 1'b1;
                e.px  = ~mBuf[15 - (h - mCx)];
            end
            e.addr = (fetchPhase == 1) ? {fetchRow, 1'b0} :
                     (fetchPhase == 2) ? {fetchRow, 1'b1} : 5'd0;
            fetchPhase = (fetchPhase == 1) ? 2 : 0;
            if (pv && h == 640) begin
                if (v == 524) begin
                    mCx = int'(mouseX); mCy = int'(mouseY); mEn = cursorEn;
                end
                tline = (v == 524) ? 0 : v + 1;
                hit = mEn && tline < 480 && tline >= mCy && tline - mCy < 16;
                if (hit) begin
                    fetchRow   = 4'(tline - mCy);
                    fetchPhase = 1;
                    mBuf = {romMem[2 * (tline - mCy)], romMem[2 * (tline - mCy) + 1]};
                end else begin
                    mBuf = 16'hFFFF;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Near the cursor a line shows column 0 and a window around the box; every line ends
    // with the fetch trigger and four blanking cycles with pix_valid low over the cursor column.
    task automatic doLine(input int v);
        int lo;
        int hi;
        if (v + 1 >= mCy && v <= mCy + 16) begin
            applyStimulus(1'b0, 1'b1, 0, v);
            lo = (mCx >= 2) ? mCx - 2 : 1;
            hi = (mCx + 17 > 639) ? 639 : mCx + 17;
            for (int h = lo; h <= hi; h++) applyStimulus(1'b0, 1'b1, h, v);
        end
        applyStimulus(1'b0, 1'b1, 640, v);
        for (int b = 0; b < 4; b++) applyStimulus(1'b0, 1'b0, mCx, v);
    endtask

    task automatic runFrame(input int mx, input int my, input bit en, input int chgLine, input int chgY);
        mouseX = 10'(mx); mouseY = 10'(my); cursorEn = en;
        doLine(524);
        for (int v = 0; v < 524; v++) begin
            if (v == chgLine) mouseY = 10'(chgY);
            doLine(v);
        end
    endtask

    always begin
        expRec_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
        end else if (outValid === 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected: out_valid got 1 expected no output");
        end
    end

    initial begin
        for (int r = 0; r < 16; r++) begin
            romMem[2 * r]     = 8'h5A ^ 8'(r * 7);
            romMem[2 * r + 1] = 8'hC3 ^ 8'(r * 3);
        end
        romMem[0]  = 8'h9F;
        romMem[1]  = 8'hFF;
        romMem[20] = 8'h80;
        romMem[21] = 8'hFF;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 100 + i, 50);

        // Lines before the first frame start must not fetch.
        mouseX = 10'd100; mouseY = 10'd50; cursorEn = 1'b1;
        for (int v = 520; v < 524; v++) doLine(v);

        runFrame(100, 50, 1'b1, -1, 0);
        runFrame(100, 50, 1'b1, 100, 200);
        runFrame(100, 200, 1'b1, -1, 0);
        runFrame(630, 470, 1'b1, -1, 0);
        runFrame(0, 0, 1'b1, -1, 0);
        runFrame(300, 100, 1'b0, -1, 0);

        // Reset lands while the row-5 fetch for line 20 is in FETCH_L.
        mouseX = 10'd200; mouseY = 10'd15; cursorEn = 1'b1;
        doLine(524);
        for (int v = 0; v < 19; v++) doLine(v);
        applyStimulus(1'b0, 1'b1, 640, 19);
        applyStimulus(1'b0, 1'b0, 200, 19);
        applyStimulus(1'b1, 1'b0, 200, 19);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 200, 19);
        for (int h = 0; h < 18; h++) applyStimulus(1'b0, 1'b1, h, 20);
        for (int h = 195; h < 220; h++) applyStimulus(1'b0, 1'b1, h, 20);
        for (int v = 20; v < 24; v++) doLine(v);
        runFrame(200, 15, 1'b1, -1, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
